control_puntaje: RTL and testbench

CONTROL_PUNTAJE -- requirements
Module: control_puntaje

---
 rtl/control_puntaje.sv | 134 +++++++++++++
 tb/tb_control_puntaje.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_puntaje.sv
// Rhythm-game scoring controller: song FSM, 4-lane round-robin hit
// arbiter, combo-weighted saturating score, best-score tracking and an
// alternating score/best-score display during the end-of-song screen.
module control_puntaje #(
  parameter int BLINK_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        fin,
  input  logic [3:0]  golpe_req,
  input  logic [7:0]  golpe_calidad,
  output logic [3:0]  golpe_ack,
  output logic [12:0] puntuacion,
  output logic [12:0] puntuacion_max,
  output logic [12:0] puntuacion_display,
  output logic [3:0]  combo,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    JUEGO = 2'b01,
    FIN   = 2'b10
  } estado_t;

  localparam logic [12:0] SCORE_SAT = 13'h1FFF;

  estado_t            estado_q;
  logic [1:0]         ptr_q;
  logic [12:0]        punt_q;
  logic [12:0]        max_q;
  logic [3:0]         combo_q;
  logic [BLINK_W-1:0] cnt_q;

  logic [3:0]  grant;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        hit;
  logic [1:0]  cal;
  logic [2:0]  base;
  logic [2:0]  mult;
  logic [4:0]  pts;
  logic [13:0] sum;
  logic [12:0] punt_nxt;
  logic [3:0]  combo_nxt;

  // Round-robin pick: first requesting lane at or after the pointer, only while playing
  always_comb begin
    grant = 4'b0000;
    win   = ptr_q;
    idx   = 2'b00;
    hit   = 1'b0;
    if (estado_q == JUEGO) begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr_q + 2'(i);
        if (!hit && golpe_req[idx]) begin
          hit = 1'b1;
          win = idx;
        end
      end
    end
    if (hit) grant[win] = 1'b1;
  end

  // Points for the winning lane; multiplier uses the combo before this hit
  always_comb begin
    cal = golpe_calidad[{win, 1'b0} +: 2];
    unique case (cal)
      2'b00:   base = 3'd0;
      2'b01:   base = 3'd1;
      2'b10:   base = 3'd2;
      default: base = 3'd4;
    endcase
    mult      = {1'b0, combo_q[3:2]} + 3'd1;
    pts       = 5'(base) * 5'(mult);
    sum       = {1'b0, punt_q} + {9'd0, pts};
    punt_nxt  = (sum > {1'b0, SCORE_SAT}) ? SCORE_SAT : sum[12:0];
    combo_nxt = (cal == 2'b00) ? 4'd0 :
                (combo_q == 4'd15) ? 4'd15 : combo_q + 4'd1;
  end

  // Song FSM with scoring, pointer, best-score and blink-counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      ptr_q    <= 2'd0;
      punt_q   <= '0;
      max_q    <= '0;
      combo_q  <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= '0;
      case (estado_q)
        IDLE: begin
          if (start) begin
            estado_q <= JUEGO;
            punt_q   <= '0;
            combo_q  <= '0;
          end
        end
        JUEGO: begin
          // a hit granted together with fin is still scored on this edge
          if (hit) begin
            punt_q  <= punt_nxt;
            combo_q <= combo_nxt;
            ptr_q   <= win + 2'd1;
          end
          if (fin) estado_q <= FIN;
        end
        FIN: begin
          // score is frozen in FIN, so repeating the compare is harmless
          if (punt_q > max_q) max_q <= punt_q;
          if (start) begin
            estado_q <= JUEGO;
            punt_q   <= '0;
            combo_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign golpe_ack          = grant;
  assign puntuacion         = punt_q;
  assign puntuacion_max     = max_q;
  assign combo              = combo_q;
  assign estado             = estado_q;
  assign puntuacion_display = (estado_q == FIN && cnt_q[BLINK_W-1]) ? max_q : punt_q;

endmodule

// File: tb/tb_control_puntaje.sv
// Bench for control_puntaje: directed songs; expected ack/score/combo per
// grant go into a scoreboard queue, a negedge monitor pops and compares.
module tb_control_puntaje;
  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        fin = 1'b0;
  logic [3:0]  golpe_req = 4'd0;
  logic [7:0]  golpe_calidad = 8'd0;
  logic [3:0]  golpe_ack;
  logic [12:0] puntuacion;
  logic [12:0] puntuacion_max;
  logic [12:0] puntuacion_display;
  logic [3:0]  combo;
  logic [1:0]  estado;

  control_puntaje #(.BLINK_W(BW)) dut (
    .clk(clk), .reset(reset), .start(start), .fin(fin),
    .golpe_req(golpe_req), .golpe_calidad(golpe_calidad),
    .golpe_ack(golpe_ack), .puntuacion(puntuacion),
    .puntuacion_max(puntuacion_max), .puntuacion_display(puntuacion_display),
    .combo(combo), .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ack;
    int         score;
    int         cmb;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int ms = 0;
  int mc = 0;
  int mptr = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // expected outcome of one granted hit
  task automatic push_hit(input int lane, input int q);
    int   base;
    int   mult;
    exp_t e;
    base = (q == 0) ? 0 : (q == 1) ? 1 : (q == 2) ? 2 : 4;
    mult = mc / 4 + 1;
    ms = ms + base * mult;
    if (ms > 8191) ms = 8191;
    mc = (q == 0) ? 0 : ((mc < 15) ? mc + 1 : 15);
    mptr = (lane + 1) % 4;
    e.ack = 4'(1 << lane);
    e.score = ms;
    e.cmb = mc;
    sbq.push_back(e);
  endtask

  // one cycle of requests (all lanes same quality) while playing
  task automatic drive(input logic [3:0] req, input int q, input logic f);
    int w;
    w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && req[(mptr + i) % 4]) w = (mptr + i) % 4;
    if (w >= 0) push_hit(w, q);
    golpe_req = req;
    golpe_calidad = {4{2'(q)}};
    fin = f;
    @(posedge clk); #1;
    golpe_req = 4'd0;
    fin = 1'b0;
  endtask

  task automatic pulse_start(input bit clears);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (clears) begin
      ms = 0;
      mc = 0;
    end
  endtask

  task automatic pulse_fin();
    fin = 1'b1;
    @(posedge clk); #1;
    fin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: ack compared when it shows, score/combo one cycle later
  initial begin
    exp_t pend;
    bit   hp;
    hp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hp = 1'b0;
      end else begin
        if (hp) begin
          chk("sb_score", int'(puntuacion), pend.score);
          chk("sb_combo", int'(combo), pend.cmb);
          hp = 1'b0;
        end
        if (golpe_ack != 4'd0) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected_ack", int'(golpe_ack), 0);
          end else begin
            pend = sbq.pop_front();
            chk("sb_ack", int'(golpe_ack), int'(pend.ack));
            hp = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #1 reset = 1'b1;
    #3;
    chk("rst_estado", int'(estado), 0);
    chk("rst_score", int'(puntuacion), 0);
    chk("rst_max", int'(puntuacion_max), 0);
    chk("rst_combo", int'(combo), 0);
    chk("rst_disp", int'(puntuacion_display), 0);
    chk("rst_ack", int'(golpe_ack), 0);
    @(posedge clk); #1 reset = 1'b0;

    // requests in IDLE are never granted; stays IDLE without start
    golpe_req = 4'hF;
    golpe_calidad = 8'hFF;
    @(negedge clk);
    chk("idle_ack", int'(golpe_ack), 0);
    chk("idle_estado", int'(estado), 0);
    golpe_req = 4'd0;
    @(posedge clk); #1;

    // song A: single perfect on lane 2
    pulse_start(1);
    chk("start_estado", int'(estado), 1);
    drive(4'b0100, 3, 1'b0);
    chk("lane2_score", int'(puntuacion), 4);
    chk("lane2_combo", int'(combo), 1);
    drive(4'b1000, 0, 1'b0);
    chk("miss_score", int'(puntuacion), 4);
    pulse_fin();
    idle(1);
    chk("finA_estado", int'(estado), 2);
    chk("finA_max", int'(puntuacion_max), 4);

    // song B: continuous ok on all lanes, pointer starts at lane 0
    pulse_start(1);
    chk("startB_score", int'(puntuacion), 0);
    chk("startB_combo", int'(combo), 0);
    chk("startB_max", int'(puntuacion_max), 4);
    repeat (16) drive(4'hF, 1, 1'b0);
    chk("rr16_score", int'(puntuacion), 40);
    chk("rr16_combo", int'(combo), 15);
    drive(4'hF, 0, 1'b0);
    repeat (9) drive(4'hF, 1, 1'b0);
    chk("combo9_score", int'(puntuacion), 55);
    chk("combo9_combo", int'(combo), 9);
    drive(4'hF, 0, 1'b0);
    chk("miss9_score", int'(puntuacion), 55);
    chk("miss9_combo", int'(combo), 0);
    drive(4'hF, 3, 1'b0);
    chk("after_miss_score", int'(puntuacion), 59);
    repeat (6) drive(4'hF, 3, 1'b0);
    drive(4'hF, 2, 1'b0);
    drive(4'hF, 3, 1'b0);
    drive(4'hF, 2, 1'b0);
    drive(4'hF, 1, 1'b1);        // last hit coincides with fin
    chk("finB_estado", int'(estado), 2);
    chk("finB_score", int'(puntuacion), 120);
    idle(1);
    chk("finB_max", int'(puntuacion_max), 120);

    // song C: ends at 80, start mid-song ignored
    pulse_start(1);
    chk("startC_score", int'(puntuacion), 0);
    chk("startC_max", int'(puntuacion_max), 120);
    repeat (8) drive(4'hF, 3, 1'b0);
    pulse_start(0);
    chk("ign_start_estado", int'(estado), 1);
    chk("ign_start_score", int'(puntuacion), 48);
    chk("ign_start_combo", int'(combo), 8);
    repeat (4) drive(4'hF, 1, 1'b0);
    drive(4'hF, 3, 1'b0);
    drive(4'hF, 1, 1'b0);
    chk("endC_score", int'(puntuacion), 80);
    pulse_fin();
    golpe_req = 4'hF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("blink_disp", int'(puntuacion_display), ((k % 16) >= 8) ? 120 : 80);
      chk("fin_ack", int'(golpe_ack), 0);
    end
    golpe_req = 4'd0;
    chk("finC_max", int'(puntuacion_max), 120);
    @(posedge clk); #1;

    // song D: drive score to 8190, then saturate
    pulse_start(1);
    repeat (2) drive(4'hF, 1, 1'b0);
    repeat (10) drive(4'hF, 3, 1'b0);
    repeat (506) drive(4'hF, 3, 1'b0);
    drive(4'hF, 1, 1'b0);
    chk("pre_sat_score", int'(puntuacion), 8190);
    drive(4'hF, 3, 1'b0);
    chk("sat_score", int'(puntuacion), 8191);
    drive(4'hF, 3, 1'b0);
    chk("sat_hold_score", int'(puntuacion), 8191);
    chk("sat_combo", int'(combo), 15);
    pulse_fin();
    idle(1);
    chk("finD_max", int'(puntuacion_max), 8191);

    // clean reset, then song E reaches 50 and is reset mid-cycle
    reset = 1'b1;
    #2 reset = 1'b0;
    ms = 0; mc = 0; mptr = 0;
    idle(1);
    chk("rst2_max", int'(puntuacion_max), 0);
    pulse_start(1);
    repeat (2) drive(4'hF, 3, 1'b0);
    repeat (2) drive(4'hF, 2, 1'b0);
    repeat (4) drive(4'hF, 3, 1'b0);
    drive(4'hF, 2, 1'b0);
    chk("songE_score", int'(puntuacion), 50);
    idle(1);
    #2;
    golpe_req = 4'hF;
    reset = 1'b1;
    #1;
    chk("arst_estado", int'(estado), 0);
    chk("arst_score", int'(puntuacion), 0);
    chk("arst_max", int'(puntuacion_max), 0);
    chk("arst_combo", int'(combo), 0);
    chk("arst_disp", int'(puntuacion_display), 0);
    chk("arst_ack", int'(golpe_ack), 0);
    golpe_req = 4'd0;
    @(posedge clk); #1 reset = 1'b0;
    ms = 0; mc = 0; mptr = 0;
    idle(3);
    chk("post_rst_estado", int'(estado), 0);
    chk("post_rst_max", int'(puntuacion_max), 0);

    // pointer back at lane 0 after reset
    pulse_start(1);
    drive(4'hF, 1, 1'b0);
    chk("ptr_rst_score", int'(puntuacion), 1);
    pulse_fin();
    idle(2);
    chk("finF_max", int'(puntuacion_max), 1);

    idle(2);
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
